// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default operand width shared by the ALU arbiter
package alu_pkg;
  localparam int REGISTER_LEN = 10;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LT   = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin grant; on a tie the requester that did not win last time wins
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = |valid;
    grant = &valid ? ~last : valid[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: serialises two requesters onto one shared combinational ALU and routes results back
module alu_arbiter #(
  parameter int REGISTER_LEN = alu_pkg::REGISTER_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2:0]              req_op_0,
  input  logic [2:0]              req_op_1,
  input  logic [3:0]              req_cal_0,
  input  logic [3:0]              req_cal_1,
  input  logic [REGISTER_LEN-1:0] req_a_0,
  input  logic [REGISTER_LEN-1:0] req_a_1,
  input  logic [REGISTER_LEN-1:0] req_b_0,
  input  logic [REGISTER_LEN-1:0] req_b_1,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [REGISTER_LEN:0]   rsp_r,
  output logic [2:0]              alu_op,
  output logic [3:0]              alu_cal,
  output logic [REGISTER_LEN-1:0] alu_a,
  output logic [REGISTER_LEN-1:0] alu_b,
  input  logic [REGISTER_LEN:0]   alu_r,
  output logic                    busy
);
  import alu_pkg::*;
  state_t state, next_state;
  logic [2:0] op_q;
  logic [3:0] cal_q;
  logic [REGISTER_LEN-1:0] a_q, b_q;
  logic [REGISTER_LEN:0] res_q;
  logic tag, last_grant, grant, grant_valid, accept;
  rr_pick2 u_pick (
    .valid(req_valid),
    .last(last_grant),
    .grant(grant),
    .grant_valid(grant_valid)
  );
  always_comb begin
    accept = (state == IDLE) && grant_valid;
    req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state == RESP) ? (tag ? 2'b10 : 2'b01) : 2'b00;
    busy = state != IDLE;
    next_state = (state == IDLE) ? (accept ? EXEC : IDLE) :
                 (state == EXEC) ? RESP :
                 (rsp_ready[tag] ? IDLE : RESP);
  end
  assign alu_op = op_q;
  assign alu_cal = cal_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp_r = res_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      tag <= 1'b0;
      op_q <= '0;
      cal_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        tag <= grant;
        last_grant <= grant;
        op_q <= grant ? req_op_1 : req_op_0;
        cal_q <= grant ? req_cal_1 : req_cal_0;
        a_q <= grant ? req_a_1 : req_a_0;
        b_q <= grant ? req_b_1 : req_b_0;
      end
      if (state == EXEC) res_q <= alu_r;
    end
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer for the shared combinational ALU. Two requesters (fetch/PC-update path and execute path) each present one ALU operation per valid/ready handshake. The block serialises the operations onto the single ALU, holds operands stable for one execute cycle, captures the result and returns it to the originating requester through a response handshake. The ALU is instantiated by the parent; this block drives its inputs and samples its output.

## Interface
- REGISTER_LEN, 10, operand width; the result is REGISTER_LEN+1 bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester operation valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_op_0 / req_op_1  in  3 each  ALU opcode
- req_cal_0 / req_cal_1  in  4 each  immediate (Cal_value)
- req_a_0 / req_a_1, req_b_0 / req_b_1  in  REGISTER_LEN each  operands
- rsp_valid  out  2  per-requester result valid; at most one bit high
- rsp_ready  in  2  per-requester result accept
- rsp_r  out  REGISTER_LEN+1  result, shared by both response ports
- alu_op  out  3, alu_cal  out  4, alu_a / alu_b  out  REGISTER_LEN  ALU inputs
- alu_r  in  REGISTER_LEN+1  ALU result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is computed combinationally from req_valid and last_grant. If exactly one requester is valid, it is granted. If both are valid, the requester that is not last_grant is granted. req_ready[g] = 1 for the granted requester only. On req_valid[g] & req_ready[g]: latch op/cal/a/b into the operand register, latch tag = g, update last_grant = g, go to EXEC. With no valid requester, stay in IDLE and keep req_ready = 0.
- EXEC: alu_* are driven from the operand register (they are always driven from it). At the end of the cycle, capture alu_r into the result register and go to RESP.
- RESP: rsp_valid[tag] = 1 and rsp_r = result register. On rsp_ready[tag], go to IDLE. rsp_ready of the non-tagged port is ignored. The result and rsp_valid hold indefinitely under backpressure.
- req_ready = 0 in EXEC and RESP. Requesters may hold or change req_valid freely; nothing is sampled outside IDLE.
- Width rule: the result is passed through unmodified. The ALU computes in REGISTER_LEN+1 bits: subtraction wraps two's-complement at that width, addition carries into the MSB, and op 001 yields 0 or 1.
- Reset (asynchronous, any state, mid-operation included): state = IDLE, last_grant = 1 so that requester 0 wins the first tie. Operand, result and tag registers are cleared. Any in-flight operation and pending response are discarded.
- Reset values: req_ready = 0 (combinational, from IDLE and no valid), rsp_valid = 0, rsp_r = 0, alu_op = 0, alu_cal = 0, alu_a = 0, alu_b = 0, busy = 0.

## Timing
- Accept edge at cycle N, EXEC in cycle N+1, rsp_valid high from cycle N+2.
- Minimum initiation interval: 3 cycles (accept, EXEC, RESP with rsp_ready already high). IDLE is re-entered after the response handshake edge.
- req_ready depends combinationally on req_valid. rsp_valid, rsp_r, alu_* and busy are registered or decoded from state only.
- alu_* are stable for the whole EXEC cycle. Because the ALU is combinational, its path is one clk period from the operand register to the result register.

## Structure
- Shared package alu_pkg: opcode localparams (OP_PASS = 000, OP_LT = 001, OP_ADDI = 010, OP_SUBI = 011, OP_ADD = 100, OP_SUB = 101, OP_AND = 110, OP_OR = 111), the FSM state encoding, and the default REGISTER_LEN.
- One sub-module, rr_pick2: inputs valid[1:0] and last; output grant index and grant_valid. Purely combinational. The FSM, operand/result registers and handshakes stay in alu_arbiter.

## Test plan
- Single op: req0 op=100, a=1023, b=1 -> accepted at N, alu_op=100 at N+1, rsp_valid[0] at N+2 with rsp_r=11'h400.
- Wrap and immediate: req1 op=101, a=3, b=5 -> rsp_r=11'h7FE. Then op=010, a=10, cal=15 -> rsp_r=25. Then op=001, a=2, b=7 -> rsp_r=1.
- Tie fairness: both valid continuously after reset -> grant order 0,1,0,1. Each response is on the correct rsp_valid bit, and req_ready is never high on both bits.
- Backpressure: rsp_ready[0]=0 for 5 cycles in RESP -> rsp_valid and rsp_r are held, req_ready stays 0 and busy stays 1. rsp_ready[1]=1 during this time has no effect.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs return to reset values asynchronously, with no response issued. After release, with both valid, requester 0 is granted first.
- Idle: no req_valid for 10 cycles -> state stays IDLE, busy=0, and alu_* hold the last operands.
